seq_multiplier: RTL



---
 rtl/mult_pkg.sv | 15 +
 rtl/twos_neg.sv | 12 +
 rtl/seq_multiplier.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier and the controller decode.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // Opcode encodings the controller decode steers to this unit.
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] OUT   = 6'b111111;

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement negate: dout = en ? -din : din.
module twos_neg #(
  parameter int N = 32
) (
  input  logic         en,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  assign dout = en ? (~din + N'(1)) : din;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, signed/unsigned, start/busy/done handshake.
// Define MULT_OVF_EN to add the ovf output (product does not fit in WIDTH bits).
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int  WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dataOut
`ifdef MULT_OVF_EN
  ,
  output logic                 ovf
`endif
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_mag_q, a_mag_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   data_out_q, data_out_d;
`ifdef MULT_OVF_EN
  logic                 sgn_q, sgn_d;
  logic                 ovf_q, ovf_d;
`endif

  logic [WIDTH-1:0]     a_mag, b_mag, addend;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   res;

  twos_neg #(.N(WIDTH)) u_neg_a (
    .en   (is_signed & dataA[WIDTH-1]),
    .din  (dataA),
    .dout (a_mag)
  );

  twos_neg #(.N(WIDTH)) u_neg_b (
    .en   (is_signed & dataB[WIDTH-1]),
    .din  (dataB),
    .dout (b_mag)
  );

  twos_neg #(.N(2*WIDTH)) u_neg_res (
    .en   (neg_q),
    .din  (prod_q),
    .dout (res)
  );

  // Carry out of the upper-half add becomes the new product MSB after the shift.
  assign addend = prod_q[0] ? a_mag_q : '0;
  assign sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};

  always_comb begin
    state_d    = state_q;
    a_mag_d    = a_mag_q;
    prod_d     = prod_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
`ifdef MULT_OVF_EN
    sgn_d      = sgn_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // The done cycle is still IDLE; a start there is dropped.
        if (start && !done_q) begin
          a_mag_d = a_mag;
          prod_d  = {{WIDTH{1'b0}}, b_mag};
          cnt_d   = CNT_W'(WIDTH);
          neg_d   = is_signed & (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
          busy_d  = 1'b1;
          state_d = ST_RUN;
`ifdef MULT_OVF_EN
          sgn_d   = is_signed;
`endif
        end
      end
      ST_RUN: begin
        prod_d = {sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        data_out_d = res;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
`ifdef MULT_OVF_EN
        ovf_d = sgn_q ? (res[2*WIDTH-1:WIDTH] != {WIDTH{res[WIDTH-1]}})
                      : (res[2*WIDTH-1:WIDTH] != '0);
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_mag_q    <= '0;
      prod_q     <= '0;
      cnt_q      <= '0;
      neg_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
`ifdef MULT_OVF_EN
      sgn_q      <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_mag_q    <= a_mag_d;
      prod_q     <= prod_d;
      cnt_q      <= cnt_d;
      neg_q      <= neg_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
`ifdef MULT_OVF_EN
      sgn_q      <= sgn_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign dataOut = data_out_q;
`ifdef MULT_OVF_EN
  assign ovf     = ovf_q;
`endif

endmodule
